// File: rtl/fetch_redirect_unit_pkg.sv
// rtl/fetch_redirect_unit_pkg.sv - shared constants and state encoding for the fetch stage
package fetch_redirect_unit_pkg;

    localparam int          DBITS_DEF    = 32;
    localparam logic [31:0] START_PC_DEF = 32'h0000_0040;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    // Primary opcode field values of the 3220 ISA
    localparam logic [3:0] OP_ALUR = 4'b1100;
    localparam logic [3:0] OP_ALUI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0111;
    localparam logic [3:0] OP_SW   = 4'b0011;
    localparam logic [3:0] OP_CMPR = 4'b1101;
    localparam logic [3:0] OP_CMPI = 4'b0101;
    localparam logic [3:0] OP_BCOND = 4'b0010;
    localparam logic [3:0] OP_JAL  = 4'b0110;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_reg_ifdec.sv
// rtl/pc_reg_ifdec.sv - IF/DEC pipeline register with hold and flush controls
module pc_reg_ifdec
    import fetch_redirect_unit_pkg::*;
#(
    parameter int               DBITS    = DBITS_DEF,
    parameter logic [DBITS-1:0] NOP_INST = DBITS'(NOP_INST_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold_i,
    input  logic             flush_i,
    input  logic [DBITS-1:0] inst_i,
    input  logic [DBITS-1:0] pc_i,
    output logic [DBITS-1:0] inst_o,
    output logic [DBITS-1:0] pc_o,
    output logic [DBITS-1:0] pcplus_o,
    output logic             valid_o
);

    logic [DBITS-1:0] inst_q;
    logic [DBITS-1:0] pc_q;
    logic [DBITS-1:0] pcplus_q;
    logic             valid_q;

    // Flush only kills the instruction; the PC fields keep their old values
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q   <= NOP_INST;
            pc_q     <= '0;
            pcplus_q <= '0;
            valid_q  <= 1'b0;
        end else if (flush_i) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            inst_q   <= inst_i;
            pc_q     <= pc_i;
            pcplus_q <= pc_i + DBITS'(4);
            valid_q  <= 1'b1;
        end
    end

    assign inst_o   = inst_q;
    assign pc_o     = pc_q;
    assign pcplus_o = pcplus_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC register, redirect/bubble FSM and IF/DEC handoff
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter int               DBITS    = DBITS_DEF,
    parameter logic [DBITS-1:0] START_PC = DBITS'(START_PC_DEF),
    parameter logic [DBITS-1:0] NOP_INST = DBITS'(NOP_INST_DEF),
    parameter int               BUBBLES  = 1,
    parameter int               CNTBITS  = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic [DBITS-1:0]   imem_addr,
    input  logic [DBITS-1:0]   imem_data,
    input  logic               IF_stall,
    input  logic               redirect,
    input  logic [DBITS-1:0]   redirect_pc,
    output logic [DBITS-1:0]   DEC_inst,
    output logic [DBITS-1:0]   DEC_pc,
    output logic [DBITS-1:0]   DEC_pcplus,
    output logic               DEC_valid,
    output logic [CNTBITS-1:0] redirect_count,
    output logic               misalign_err
);

    localparam logic [2:0] BUB_INIT = 3'(BUBBLES - 1);

    fetch_state_e       state_q, state_d;
    logic [DBITS-1:0]   pc_q, pc_d;
    logic [2:0]         bub_q, bub_d;
    logic [CNTBITS-1:0] cnt_q, cnt_d;
    logic               mis_q, mis_d;
    logic               ifdec_hold;
    logic               ifdec_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= START_PC;
            bub_q   <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bub_q   <= bub_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        bub_d       = bub_q;
        cnt_d       = cnt_q;
        mis_d       = mis_q;
        ifdec_hold  = 1'b1;
        ifdec_flush = 1'b0;
        if (redirect) begin
            pc_d        = {redirect_pc[DBITS-1:2], 2'b00};
            ifdec_flush = 1'b1;
            bub_d       = BUB_INIT;
            state_d     = (BUBBLES == 1) ? ST_RUN : ST_BUBBLE;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNTBITS'(1);
            end
            if (redirect_pc[1:0] != 2'b00) begin
                mis_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_BOOT, ST_RUN: begin
                    state_d = ST_RUN;
                    if (!IF_stall) begin
                        ifdec_hold = 1'b0;
                        pc_d       = pc_q + DBITS'(4);
                    end
                end
                // Leaving on the last count makes the target fetch land BUBBLES+1 cycles after redirect
                ST_BUBBLE: begin
                    bub_d = (bub_q == 3'd0) ? 3'd0 : bub_q - 3'd1;
                    if (bub_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    pc_reg_ifdec #(
        .DBITS    (DBITS),
        .NOP_INST (NOP_INST)
    ) u_ifdec (
        .clk      (clk),
        .reset    (reset),
        .hold_i   (ifdec_hold),
        .flush_i  (ifdec_flush),
        .inst_i   (imem_data),
        .pc_i     (pc_q),
        .inst_o   (DEC_inst),
        .pc_o     (DEC_pc),
        .pcplus_o (DEC_pcplus),
        .valid_o  (DEC_valid)
    );

    assign imem_addr      = pc_q;
    assign redirect_count = cnt_q;
    assign misalign_err   = mis_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - randomized and directed bench for fetch_redirect_unit
module tb_fetch_redirect_unit;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, IF_stall, redirect;
    logic [31:0] redirect_pc;

    logic [31:0] addr1, data1, inst1, pc1, pcp1;
    logic        val1, mis1;
    logic [15:0] cnt1;
    logic [31:0] addr3, data3, inst3, pc3, pcp3;
    logic        val3, mis3;
    logic [3:0]  cnt3;

    assign data1 = mem_word(addr1);
    assign data3 = mem_word(addr3);

    fetch_redirect_unit #(.BUBBLES(1)) dut1 (
        .clk(clk), .reset(reset), .imem_addr(addr1), .imem_data(data1),
        .IF_stall(IF_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .DEC_inst(inst1), .DEC_pc(pc1), .DEC_pcplus(pcp1), .DEC_valid(val1),
        .redirect_count(cnt1), .misalign_err(mis1)
    );

    fetch_redirect_unit #(.BUBBLES(3), .CNTBITS(4)) dut3 (
        .clk(clk), .reset(reset), .imem_addr(addr3), .imem_data(data3),
        .IF_stall(IF_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .DEC_inst(inst3), .DEC_pc(pc3), .DEC_pcplus(pcp3), .DEC_valid(val3),
        .redirect_count(cnt3), .misalign_err(mis3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: after a redirect the unit is dead for BUBBLES-1 cycles, then fetches again
    logic [31:0] m_pc[2], m_inst[2], m_dpc[2], m_dpcp[2];
    logic        m_val[2], m_mis[2];
    int          m_cnt[2], m_dead[2];
    int          m_bub[2]  = '{1, 3};
    int          m_cmax[2] = '{65535, 15};

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_pc[k] = 32'h40; m_inst[k] = 32'h0; m_dpc[k] = 32'h0; m_dpcp[k] = 32'h0;
                m_val[k] = 1'b0; m_mis[k] = 1'b0; m_cnt[k] = 0; m_dead[k] = 0;
            end else if (redirect) begin
                m_pc[k]   = redirect_pc & 32'hFFFF_FFFC;
                m_val[k]  = 1'b0;
                m_inst[k] = 32'h0;
                m_dead[k] = m_bub[k] - 1;
                if (m_cnt[k] < m_cmax[k]) m_cnt[k]++;
                if (redirect_pc % 4 != 0) m_mis[k] = 1'b1;
            end else if (m_dead[k] > 0) begin
                m_dead[k]--;
            end else if (!IF_stall) begin
                m_inst[k] = mem_word(m_pc[k]);
                m_dpc[k]  = m_pc[k];
                m_dpcp[k] = m_pc[k] + 32'd4;
                m_val[k]  = 1'b1;
                m_pc[k]   = m_pc[k] + 32'd4;
            end
        end
    endtask

    task automatic check_all();
        check("m1_addr",  addr1,        m_pc[0]);
        check("m1_inst",  inst1,        m_inst[0]);
        check("m1_pc",    pc1,          m_dpc[0]);
        check("m1_pcp",   pcp1,         m_dpcp[0]);
        check("m1_valid", 32'(val1),    32'(m_val[0]));
        check("m1_cnt",   32'(cnt1),    32'(m_cnt[0]));
        check("m1_mis",   32'(mis1),    32'(m_mis[0]));
        check("m3_addr",  addr3,        m_pc[1]);
        check("m3_inst",  inst3,        m_inst[1]);
        check("m3_pc",    pc3,          m_dpc[1]);
        check("m3_pcp",   pcp3,         m_dpcp[1]);
        check("m3_valid", 32'(val3),    32'(m_val[1]));
        check("m3_cnt",   32'(cnt3),    32'(m_cnt[1]));
        check("m3_mis",   32'(mis3),    32'(m_mis[1]));
    endtask

    task automatic cycle(input logic r, input logic s, input logic d, input logic [31:0] p);
        reset       = r;
        IF_stall    = s;
        redirect    = d;
        redirect_pc = p;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic        prev_rst;
        logic        r, s, d;
        logic [31:0] p;

        // Reset and boot
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("rst_addr",  addr1, 32'h40);
        check("rst_valid", 32'(val1), 32'd0);
        check("rst_inst",  inst1, 32'h0);
        check("rst_cnt",   32'(cnt1), 32'd0);
        check("rst_mis",   32'(mis1), 32'd0);
        cycle(0, 0, 0, 0);
        check("boot_inst",  inst1, mem_word(32'h40));
        check("boot_pc",    pc1, 32'h40);
        check("boot_pcp",   pcp1, 32'h44);
        check("boot_valid", 32'(val1), 32'd1);

        // Stall at 0x48
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            check("stall_addr", addr1, 32'h48);
            check("stall_dpc",  pc1, 32'h44);
        end
        cycle(0, 0, 0, 0);
        check("unstall_dpc", pc1, 32'h48);

        // Redirect from 0x50 to 0x100
        cycle(0, 0, 0, 0);
        check("pre_redir_addr", addr1, 32'h50);
        cycle(0, 0, 1, 32'h100);
        check("redir_valid", 32'(val1), 32'd0);
        check("redir_addr",  addr1, 32'h100);
        check("redir_cnt",   32'(cnt1), 32'd1);
        cycle(0, 0, 0, 0);
        check("redir_dpc",   pc1, 32'h100);
        check("redir_vld1",  32'(val1), 32'd1);

        // Redirect wins over stall; misaligned target
        cycle(0, 1, 1, 32'h203);
        check("mis_addr", addr1, 32'h200);
        check("mis_err",  32'(mis1), 32'd1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        check("mis_sticky", 32'(mis1), 32'd1);

        // Back-to-back redirects with three bubbles
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("mis_cleared", 32'(mis1), 32'd0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'h80);
        check("b2b_first", 32'(val3), 32'd0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'hC0);
        for (int i = 0; i < 3; i++) begin
            check("b2b_bubble", 32'(val3), 32'd0);
            check("b2b_addr",   addr3, 32'hC0);
            cycle(0, 0, 0, 0);
        end
        check("b2b_dpc",   pc3, 32'hC0);
        check("b2b_valid", 32'(val3), 32'd1);
        check("b2b_cnt",   32'(cnt3), 32'd2);

        // Wrap past the top of the address space, then reset inside a bubble
        cycle(0, 0, 1, 32'hFFFF_FFFC);
        check("wrap_pre", addr1, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        check("wrap_addr", addr1, 32'h0);
        check("wrap_pcp",  pcp1, 32'h0);
        cycle(1, 0, 0, 0);
        check("midrst_addr",  addr3, 32'h40);
        check("midrst_cnt",   32'(cnt3), 32'd0);
        check("midrst_valid", 32'(val3), 32'd0);
        cycle(0, 0, 0, 0);
        check("midrst_boot_pc", pc3, 32'h40);

        // Saturation of the narrow counter
        for (int i = 0; i < 20; i++) cycle(0, 0, 1, $urandom & 32'h0000_0FFC);
        check("sat_cnt3", 32'(cnt3), 32'd15);
        check("sat_cnt1", 32'(cnt1), 32'd20);

        // Random traffic
        prev_rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 63) == 0);
            d = ($urandom_range(0, 7) == 0);
            s = prev_rst ? 1'b0 : ($urandom_range(0, 3) == 0);
            p = $urandom;
            if ($urandom_range(0, 3) == 0) p = 32'hFFFF_FFF0 | (p & 32'hF);
            else p = p & 32'h0000_0FFF;
            if ($urandom_range(0, 1) == 0) p = p & 32'hFFFF_FFFC;
            cycle(r, s, d, p);
            prev_rst = r;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
Instruction-fetch stage of the 3220 pipeline. It is the consumer of the hazard/redirect interface: it owns the PC register and drives the instruction-memory address. It holds or advances the IF/DEC pipeline register under stall, and on a redirect it loads the target PC and flushes. Sits between instruction memory and the decode stage; stall and redirect come from the hazard logic.

Parameters:
DBITS, 32, address/data width
START_PC, 32'h40, PC loaded on reset
NOP_INST, 32'h0, instruction word presented in DEC_inst when invalid
BUBBLES, 1, bubble cycles inserted after a redirect (1..7)
CNTBITS, 16, width of redirect performance counter

Ports:
clk  in  1  clock, all state rises on posedge
reset  in  1  synchronous, active-high
imem_addr  out  DBITS  fetch address, equals PC combinationally
imem_data  in  DBITS  instruction word, combinational read of imem_addr
IF_stall  in  1  1 = hold fetch and IF/DEC register this cycle
redirect  in  1  1 = load redirect_pc and flush
redirect_pc  in  DBITS  redirect target
DEC_inst  out  DBITS  registered instruction to decode
DEC_pc  out  DBITS  PC of DEC_inst
DEC_pcplus  out  DBITS  DEC_pc + 4
DEC_valid  out  1  DEC_* holds a real instruction
redirect_count  out  CNTBITS  saturating count of accepted redirects
misalign_err  out  1  sticky: a redirect_pc had bits[1:0] != 0

Behaviour:
- Reset (sync, sampled at posedge):
  - PC = START_PC; state = BOOT; DEC_valid = 0; DEC_inst = NOP_INST; DEC_pc = DEC_pcplus = 0.
  - redirect_count = 0; misalign_err = 0; bubble counter = 0.
  - Reset overrides every other input.
- States:
  - BOOT: one cycle; DEC_valid stays 0; then RUN. Exception: redirect in BOOT is taken exactly as in RUN.
  - RUN: normal fetch.
  - BUBBLE: post-redirect flush cycles.
- Priority each cycle: reset > redirect > IF_stall > advance.
- Redirect (any non-reset state):
  - PC <= {redirect_pc[DBITS-1:2], 2'b00}.
  - DEC_valid <= 0 and DEC_inst <= NOP_INST. DEC_pc and DEC_pcplus are don't-care but must be held.
  - Bubble counter <= BUBBLES-1. State <= BUBBLE, or RUN directly if BUBBLES == 1.
  - redirect_count increments, saturating at all-ones.
  - If redirect_pc[1:0] != 0, misalign_err <= 1 and stays set until reset.
  - A redirect during BUBBLE restarts the counter.
- BUBBLE:
  - PC held; DEC_valid held at 0; counter decrements every cycle regardless of IF_stall.
  - Counter == 0 -> RUN next cycle.
  - Total DEC_valid = 0 cycles after a redirect = BUBBLES.
- RUN, IF_stall = 1: PC and all DEC_* registers hold their values, including DEC_valid.
- RUN, advance:
  - DEC_inst <= imem_data; DEC_pc <= PC; DEC_pcplus <= PC + 4; DEC_valid <= 1.
  - PC <= PC + 4, modulo 2^DBITS: 32'hFFFF_FFFC wraps to 0, no flag.
- Latency: instruction at PC appears on DEC_inst one cycle after imem_addr = PC in RUN without stall.
- After redirect at cycle t, the target's instruction is valid on DEC_* at cycle t + BUBBLES + 1.
- Redirect and IF_stall both asserted: redirect wins and the stall is ignored for that cycle.

Decomposition:
- Shared package/include gets: opcode constants (`JAL` etc.), DBITS default, NOP_INST, START_PC, and the state encoding BOOT = 2'd0, RUN = 2'd1, BUBBLE = 2'd2.
- One natural sub-module: pc_reg_ifdec, the IF/DEC pipeline register with hold/flush controls and reset value NOP_INST.
- The FSM, PC register and counter stay in fetch_redirect_unit.

Test Plan:
1. Reset: hold reset 2 cycles, release.
   - Expect imem_addr = 32'h40 and DEC_valid = 0 for the BOOT cycle.
   - Next cycle expect DEC_inst = mem[0x40], DEC_pc = 0x40, DEC_pcplus = 0x44, DEC_valid = 1.
2. Stall: in RUN at PC = 0x48, assert IF_stall for 3 cycles.
   - Expect imem_addr = 0x48 throughout and DEC_* unchanged.
   - On release, expect DEC_pc = 0x48 one cycle later.
3. Redirect: at PC = 0x50, pulse redirect with redirect_pc = 0x100, BUBBLES = 1.
   - Expect DEC_valid = 0 for 1 cycle, then DEC_pc = 0x100 and DEC_valid = 1.
   - Expect redirect_count = 1.
4. Redirect + stall, misaligned target: assert both with redirect_pc = 0x203.
   - Expect imem_addr = 0x200 next cycle and misalign_err = 1, staying set until reset.
5. Back-to-back redirects with BUBBLES = 3: redirect to 0x80, then redirect to 0xC0 in the 2nd bubble cycle.
   - Expect 3 further DEC_valid = 0 cycles, then DEC_pc = 0xC0.
   - Expect redirect_count = 2.
6. Wrap and reset mid-operation:
   - Redirect to 32'hFFFF_FFFC, advance, and expect the next imem_addr = 0.
   - Assert reset during BUBBLE, and expect PC = 0x40, redirect_count = 0, state BOOT.
